// File: rtl/brisc_pkg.sv
// rtl/brisc_pkg.sv - shared core constants and memory-arbiter types
package brisc_pkg;

  localparam int ADDRESS_BITS           = 32;
  localparam int CACHE_LINE_OFFSET_BITS = 6;
  localparam int TAG_BITS               = ADDRESS_BITS - CACHE_LINE_OFFSET_BITS;
  localparam int REG_LEN                = 32;
  localparam int CACHE_LINE_LEN         = 512;

  // Memory command encoding follows the cache convention: 1 = load.
  localparam logic MEM_LOAD  = 1'b1;
  localparam logic MEM_STORE = 1'b0;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} arb_state_e;
  typedef enum logic {OWN_I, OWN_D} owner_e;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rtl/mem_arbiter_rr_pick2.sv - combinational 2-way round-robin selector
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // On a tie the requester that did not win last time is favoured.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares the main-memory port between the I and D caches
import brisc_pkg::*;

module mem_arbiter #(
  parameter int ADDR_W = TAG_BITS,
  parameter int DATA_W = REG_LEN,
  parameter int LINE_W = CACHE_LINE_LEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_grant,
  output logic              i_resp,
  input  logic              d_req,
  input  logic              d_store,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_grant,
  output logic              d_resp,
  output logic [LINE_W-1:0] fill_out,
  output logic              mem_req,
  output logic              mem_instr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_resp,
  input  logic [LINE_W-1:0] mem_fill
);

  arb_state_e state;
  owner_e     last_owner;
  logic [1:0] gnt;

  // Index 0 is the I cache, index 1 the D cache.
  rr_pick2 u_pick (
    .req  ({d_req, i_req}),
    .last (last_owner == OWN_D),
    .gnt  (gnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_owner <= OWN_I;
      i_grant    <= 1'b0;
      d_grant    <= 1'b0;
      mem_instr  <= MEM_LOAD;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      fill_out   <= '0;
    end else begin
      i_grant <= 1'b0;
      d_grant <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt[1]) begin
            state      <= BUSY_D;
            last_owner <= OWN_D;
            d_grant    <= 1'b1;
            mem_addr   <= d_addr;
            mem_wdata  <= d_wdata;
            mem_instr  <= d_store ? MEM_STORE : MEM_LOAD;
          end else if (gnt[0]) begin
            state      <= BUSY_I;
            last_owner <= OWN_I;
            i_grant    <= 1'b1;
            mem_addr   <= i_addr;
            mem_instr  <= MEM_LOAD;
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_resp) begin
            // A store leaves the last fill line in place.
            if (mem_instr == MEM_LOAD) begin
              fill_out <= mem_fill;
            end
            state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_req = (state == BUSY_I) || (state == BUSY_D);
  assign i_resp  = (state == RESP) && (last_owner == OWN_I);
  assign d_resp  = (state == RESP) && (last_owner == OWN_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
  import brisc_pkg::*;

  localparam int AW = TAG_BITS;
  localparam int DW = REG_LEN;
  localparam int LW = CACHE_LINE_LEN;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_grant, i_resp;
  logic          d_req = 1'b0;
  logic          d_store = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_grant, d_resp;
  logic [LW-1:0] fill_out;
  logic          mem_req, mem_instr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_resp;
  logic [LW-1:0] mem_fill;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_resp(i_resp),
    .d_req(d_req), .d_store(d_store), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_grant(d_grant), .d_resp(d_resp), .fill_out(fill_out),
    .mem_req(mem_req), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_fill(mem_fill)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_d;
    bit            store;
    bit            instr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [LW-1:0] fill;
  } exp_t;

  typedef struct {
    bit            is_d;
    bit            store;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            lat;
    bit            exp_instr;
    int            exp_grant;
    int            exp_resp;
  } vec_t;

  exp_t          sb[$];
  exp_t          cur;
  exp_t          mon_e;
  bit            cur_valid = 0;
  logic [LW-1:0] model_fill = '0;
  int            n_cmp = 0;
  int            n_fail = 0;
  bit            proto_test = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] fill_of(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    w = (a == AW'('h12)) ? 32'hDEADBEEF : (32'hA500_0000 ^ DW'(a));
    return {(LW/DW){w}};
  endfunction

  // Memory model: answers after mem_lat cycles of mem_req; force_resp injects stray pulses.
  int            mem_lat = 1;
  bit            mem_auto = 1;
  bit            mem_rand = 0;
  int            mem_cnt = 0;
  logic          auto_resp = 1'b0;
  logic          force_resp = 1'b0;
  logic [LW-1:0] auto_fill = '0;
  assign mem_resp = auto_resp | force_resp;
  assign mem_fill = auto_fill;

  initial forever begin
    @(posedge clk); #1;
    auto_resp = 1'b0;
    if (!mem_req) mem_cnt = 0;
    else if (mem_auto) begin
      mem_cnt++;
      if (mem_cnt >= mem_lat) begin
        auto_resp = 1'b1;
        auto_fill = fill_of(mem_addr);
        mem_cnt = 0;
        if (mem_rand) mem_lat = $urandom_range(1, 20);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) cur_valid = 0;
    else begin
      chk("grant_excl", i_grant & d_grant, '0);
      chk("resp_excl", i_resp & d_resp, '0);
      if (!proto_test) chk("mem_resp_protocol", mem_resp & ~mem_req, '0);
      if (i_grant || d_grant) begin
        if (sb.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_grant: i=%0b d=%0b required none", i_grant, d_grant);
        end else begin
          cur = sb[0];
          cur_valid = 1;
          chk("grant_owner", d_grant, cur.is_d);
        end
      end
      if (mem_req) begin
        if (!cur_valid) begin
          n_cmp++; n_fail++;
          $display("FAIL mem_req_unowned: got 1 required 0");
        end else begin
          chk("mem_addr", mem_addr, cur.addr);
          chk("mem_instr", mem_instr, cur.instr);
          if (cur.store) chk("mem_wdata", mem_wdata, cur.wdata);
        end
      end
      if (i_resp || d_resp) begin
        if (sb.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_resp: i=%0b d=%0b required none", i_resp, d_resp);
        end else begin
          mon_e = sb.pop_front();
          chk("resp_owner", d_resp, mon_e.is_d);
          chk("fill_out", fill_out, mon_e.fill);
        end
        cur_valid = 0;
      end
    end
  end

  task automatic expect_txn(input bit is_d, input bit store, input bit instr,
                            input logic [AW-1:0] a, input logic [DW-1:0] w);
    exp_t e;
    e.is_d = is_d; e.store = store; e.instr = instr; e.addr = a; e.wdata = w;
    if (!store) model_fill = fill_of(a);
    e.fill = model_fill;
    sb.push_back(e);
  endtask

  int gnt_cyc[$];
  bit gnt_d[$];
  int i_resp_cyc, d_resp_cyc, other_pulses;

  // Entered and left at posedge+1; cycle 0 is the entry cycle.
  task automatic drive(input bit i_on, input int i_at, input bit d_on, input int d_at,
                       input bit noise, input int budget);
    bit i_done, d_done, i_g, d_g;
    int c;
    i_done = !i_on; d_done = !d_on; i_g = 0; d_g = 0; c = 0;
    gnt_cyc.delete(); gnt_d.delete();
    i_resp_cyc = -1; d_resp_cyc = -1; other_pulses = 0;
    while (!(i_done && d_done)) begin
      if (c > budget) begin
        n_cmp++; n_fail++;
        $display("FAIL drive_timeout: got %0d cycles required <= %0d", c, budget);
        i_req = 0; d_req = 0;
        break;
      end
      if (i_on && c == i_at) i_req = 1;
      if (d_on && c == d_at) d_req = 1;
      if (noise && i_on && !d_on && i_g && !i_done) begin
        d_req = 1'($urandom_range(0, 1)); d_addr = AW'($urandom); d_wdata = $urandom;
        d_store = 1'($urandom_range(0, 1));
      end
      if (noise && d_on && !i_on && d_g && !d_done) begin
        i_req = 1'($urandom_range(0, 1)); i_addr = AW'($urandom);
      end
      @(negedge clk);
      if (i_grant) begin gnt_cyc.push_back(c); gnt_d.push_back(0); i_g = 1; end
      if (d_grant) begin gnt_cyc.push_back(c); gnt_d.push_back(1); d_g = 1; end
      if (!noise && ((!i_on && (i_grant || i_resp)) || (!d_on && (d_grant || d_resp))))
        other_pulses++;
      if (i_resp) begin
        i_req = 0; i_done = 1; i_resp_cyc = c;
        if (noise && !d_on) d_req = 0;
      end
      if (d_resp) begin
        d_req = 0; d_done = 1; d_resp_cyc = c;
        if (noise && !i_on) i_req = 0;
      end
      @(posedge clk); #1;
      c++;
    end
  endtask

  task automatic do_reset();
    rst_n = 0; i_req = 0; d_req = 0;
    sb.delete(); model_fill = '0;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{0, 0, AW'('h12),       32'h0,        4, 1, 1, 5};
    vecs[1] = '{1, 1, AW'('h3),        32'hCAFEF00D, 2, 0, 1, 3};
    vecs[2] = '{1, 0, AW'('h7),        32'h0,        1, 1, 1, 2};
    vecs[3] = '{0, 0, AW'('h3FFFFFF),  32'h0,        3, 1, 1, 4};
    vecs[4] = '{1, 1, AW'('h0),        32'hFFFFFFFF, 1, 0, 1, 2};

    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_i_grant", i_grant, '0);
    chk("rst_d_grant", d_grant, '0);
    chk("rst_i_resp", i_resp, '0);
    chk("rst_d_resp", d_resp, '0);
    chk("rst_mem_req", mem_req, '0);
    chk("rst_mem_instr", mem_instr, 1);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_fill_out", fill_out, '0);
    @(posedge clk); #1;

    for (int k = 0; k < 5; k++) begin
      if (vecs[k].is_d) begin
        d_store = vecs[k].store; d_addr = vecs[k].addr; d_wdata = vecs[k].wdata;
      end else begin
        i_addr = vecs[k].addr;
      end
      mem_lat = vecs[k].lat;
      expect_txn(vecs[k].is_d, vecs[k].store, vecs[k].exp_instr, vecs[k].addr, vecs[k].wdata);
      drive(!vecs[k].is_d, 0, vecs[k].is_d, 0, 0, 60);
      chk($sformatf("vec%0d_grant_cyc", k), (gnt_cyc.size() > 0) ? gnt_cyc[0] : -1,
          vecs[k].exp_grant);
      chk($sformatf("vec%0d_resp_cyc", k), vecs[k].is_d ? d_resp_cyc : i_resp_cyc,
          vecs[k].exp_resp);
      chk($sformatf("vec%0d_other_side", k), other_pulses, 0);
    end

    // Ties after reset: D first, then I, and the pattern repeats.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      d_store = 0; d_addr = AW'('h21); i_addr = AW'('h22); mem_lat = 2;
      expect_txn(1, 0, 1, AW'('h21), '0);
      expect_txn(0, 0, 1, AW'('h22), '0);
      drive(1, 0, 1, 0, 0, 80);
      chk("tie_count", gnt_d.size(), 2);
      if (gnt_d.size() == 2) begin
        chk("tie_first_d", gnt_d[0], 1);
        chk("tie_second_i", gnt_d[1], 0);
        chk("tie_first_cyc", gnt_cyc[0], 1);
        chk("tie_i_after_idle", gnt_cyc[1], d_resp_cyc + 2);
      end
    end

    // D request arrives while I is busy and waits for IDLE.
    i_addr = AW'('h30); d_addr = AW'('h31); d_store = 0; mem_lat = 4;
    expect_txn(0, 0, 1, AW'('h30), '0);
    expect_txn(1, 0, 1, AW'('h31), '0);
    drive(1, 0, 1, 2, 0, 80);
    chk("late_count", gnt_d.size(), 2);
    if (gnt_d.size() == 2) begin
      chk("late_i_grant", gnt_cyc[0], 1);
      chk("late_i_resp", i_resp_cyc, 5);
      chk("late_d_owner", gnt_d[1], 1);
      chk("late_d_grant", gnt_cyc[1], 7);
    end

    // Reset during BUSY_D aborts the store; a later stray mem_resp is ignored.
    mem_auto = 0;
    d_store = 1; d_addr = AW'('h5); d_wdata = 32'h11223344;
    expect_txn(1, 1, 0, AW'('h5), 32'h11223344);
    d_req = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_d_grant", d_grant, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    chk("abort_mem_req", mem_req, '0);
    chk("abort_d_resp", d_resp, '0);
    chk("abort_mem_instr", mem_instr, 1);
    chk("abort_fill_out", fill_out, '0);
    proto_test = 1;
    @(posedge clk); #1;
    force_resp = 1;
    @(posedge clk); #1;
    force_resp = 0;
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      chk("stray_resp_ignored", {i_resp, d_resp, i_grant, d_grant, mem_req}, '0);
    end
    proto_test = 0;
    mem_auto = 1;
    @(posedge clk); #1;

    // Random owners and latencies with the non-owner request toggling.
    mem_rand = 1;
    mem_lat = $urandom_range(1, 20);
    for (int t = 0; t < 30; t++) begin
      bit          use_d, st;
      logic [AW-1:0] a;
      logic [DW-1:0] w;
      use_d = 1'($urandom_range(0, 1));
      st = use_d ? 1'($urandom_range(0, 1)) : 1'b0;
      a = AW'($urandom);
      w = $urandom;
      if (use_d) begin d_store = st; d_addr = a; d_wdata = w; end
      else i_addr = a;
      expect_txn(use_d, st, ~st, a, w);
      drive(!use_d, 0, use_d, 0, 1, 100);
    end
    mem_rand = 0;

    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory port between the instruction cache (I) and the data cache (D).
- Each cache raises a miss-fill or write-through request. The arbiter grants one requester, latches its command, and drives the memory handshake.
- Returns the memory response and fill line to the owner only.
- Sits between the two cache instances and the memory model, at the top of the core.

Parameters:
- ADDR_W, default TAG_BITS (ADDRESS_BITS - CACHE_LINE_OFFSET_BITS): line-address width.
- DATA_W, default REG_LEN: store-word width for write-through.
- LINE_W, default CACHE_LINE_LEN: fill-line width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- i_req  in  1  I-cache request; held until i_resp
- i_addr  in  ADDR_W  I-cache line address
- i_grant  out  1  one-cycle pulse: I request accepted
- i_resp  out  1  one-cycle pulse: I transaction done
- d_req  in  1  D-cache request; held until d_resp
- d_store  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  D-cache line address
- d_wdata  in  DATA_W  store word
- d_grant  out  1  one-cycle pulse: D request accepted
- d_resp  out  1  one-cycle pulse: D transaction done
- fill_out  out  LINE_W  latched fill line, valid while *_resp is high
- mem_req  out  1  request to memory, held until mem_resp
- mem_instr  out  1  0 = store, 1 = load (matches the cache convention)
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched store word
- mem_resp  in  1  one-cycle pulse from memory: done
- mem_fill  in  LINE_W  line data, valid with mem_resp

Behaviour:
- Reset values (rst_n low at a clk edge):
  - state = IDLE, last_owner = I.
  - All pulses and mem_req = 0; mem_instr = 1.
  - mem_addr, mem_wdata and fill_out = 0.
  - Reset mid-transaction aborts it; mem_req drops the next cycle and no resp is issued. Memory must tolerate a withdrawn request.
- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE:
  - Sample i_req and d_req each cycle.
  - Only one requesting: grant it.
  - Both requesting: grant the one that is not last_owner (round-robin). After reset D wins the first tie.
  - On a grant in cycle T:
    - Latch addr and wdata into mem_addr/mem_wdata.
    - mem_instr = ~d_store for D, 1 for I (the I side is always a load).
    - Set last_owner; go to BUSY_x.
    - x_grant is high in T+1 and is registered.
- BUSY_x:
  - mem_req = 1 every cycle; mem_addr, mem_wdata and mem_instr are stable.
  - Stay until mem_resp = 1, then latch mem_fill into fill_out (load only; fill_out is unchanged on a store) and go to RESP.
  - Earliest mem_resp is T+1 (the first BUSY cycle); there is no timeout.
- RESP:
  - x_resp = 1 for exactly one cycle, then go to IDLE.
  - mem_req = 0. The owner must deassert x_req in its resp cycle.
- Latency: request to mem_req is 1 cycle. mem_resp to x_resp is 1 cycle. Minimum gap between transactions is 1 IDLE cycle, so back-to-back grants are 3 cycles apart minimum.
- Boundary conditions:
  - A req raised during BUSY or RESP is not granted until IDLE. That req waits; it is not dropped.
  - Request inputs are ignored outside IDLE.
  - The non-owner's req may toggle freely during a transaction without effect.
  - mem_resp arriving in IDLE or RESP is ignored (protocol error; the bench asserts it never occurs).
  - i_grant/d_grant and i_resp/d_resp are never both high in the same cycle.

Decomposition:
- Add to brisc_pkg:
  - typedef enum logic [1:0] arb_state_e {IDLE, BUSY_I, BUSY_D, RESP}.
  - typedef enum logic owner_e {OWN_I, OWN_D}.
  - Constants MEM_LOAD = 1 and MEM_STORE = 0.
- One sub-module, rr_pick2: a combinational 2-way round-robin selector with inputs req[1:0] and last, outputs gnt[1:0]. It is reusable for later multi-core or TLB-walker arbitration.
- The FSM, latches and fill register stay in mem_arbiter.

Test Plan:
- Single I load:
  - Stimulus: i_req = 1, i_addr = 0x12 at cycle 0; memory returns mem_resp at cycle 4 with mem_fill = {16{32'hDEADBEEF}}.
  - Required: i_grant at cycle 1; mem_req high cycles 1-4 with mem_instr = 1 and mem_addr = 0x12; i_resp at cycle 5 with fill_out = pattern; d_* outputs stay 0.
- D store:
  - Stimulus: d_req = 1, d_store = 1, d_addr = 0x3, d_wdata = 0xCAFEF00D; mem_resp after 2 cycles.
  - Required: mem_instr = 0 and mem_wdata = 0xCAFEF00D for the whole BUSY_D; d_resp pulses once; fill_out unchanged.
- Tie after reset:
  - Stimulus: i_req and d_req both high at cycle 0.
  - Required: D granted first; I granted at the first IDLE after d_resp. Repeating the tie alternates D, I, D, I.
- Late request:
  - Stimulus: d_req rises while BUSY_I.
  - Required: no d_grant until IDLE; the I transaction completes with mem_addr unchanged; d_grant in the cycle after IDLE.
- Reset mid-transaction:
  - Stimulus: rst_n = 0 for 1 cycle during BUSY_D.
  - Required: next cycle state = IDLE, mem_req = 0, no d_resp; a subsequent mem_resp is ignored.
- Stability check:
  - Stimulus: randomised non-owner req toggling plus random memory latency 1-20 cycles.
  - Required: grants and resps are never simultaneous across I and D; mem_addr is constant while mem_req is high.
